// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
// Parity support is selected in uart_rx with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  // Oversample divider; clamped to 1 so a too-fast baud still yields a legal counter.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned div;
    div = clk_freq / (baud_rate * oversample);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte and status pulses out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 iRx;
  logic [DATA_BITS-1:0] oData;
  logic                 oValid;
  logic                 oFrame_err;
  logic                 oParity_err;
  logic                 oBusy;

  modport master (
    input  iRx,
    output oData, oValid, oFrame_err, oParity_err, oBusy
  );

  modport slave (
    output iRx,
    input  oData, oValid, oFrame_err, oParity_err, oBusy
  );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider for the receiver: counts 0..DIV-1 and pulses at DIV-1.
// The restart input realigns the count to a detected start edge.
module uart_rx_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic iClk,
  input  logic iRst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == CW'(DIV - 1))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x-style oversampling with mid-bit sampling.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  uart_rx_if.master  bus
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BIW = $clog2(DATA_BITS);

  logic                 sync1_q, rx_s_q;
  state_e               state_q, state_d;
  logic [SCW-1:0]       samp_q, samp_d;
  logic [BIW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 restart_c;
  logic                 tick_c;
  logic                 last_tick_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  uart_rx_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .iClk    (iClk),
    .iRst    (iRst),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Final oversample tick of a bit period: mid-bit once aligned by START.
  assign last_tick_c = tick_c && (samp_q == SCW'(OVERSAMPLE - 1));

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    restart_c = 1'b0;
    busy_d    = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          restart_c = 1'b1;
          samp_d    = '0;
          bit_d     = '0;
          state_d   = START;
        end
      end

      START: begin
        if (tick_c) begin
          if (samp_q == SCW'(OVERSAMPLE / 2 - 1)) begin
            samp_d = '0;
            bit_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            samp_d = samp_q + SCW'(1);
          end
        end
      end

      DATA: begin
        if (last_tick_c) begin
          samp_d  = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIW'(1);
          end
        end else if (tick_c) begin
          samp_d = samp_q + SCW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (last_tick_c) begin
          samp_d  = '0;
          par_d   = rx_s_q;
          state_d = STOP;
        end else if (tick_c) begin
          samp_d = samp_q + SCW'(1);
        end
      end
`endif

      STOP: begin
        if (last_tick_c) begin
          samp_d = '0;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            if (par_q != (^shift_q)) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else if (tick_c) begin
          samp_d = samp_q + SCW'(1);
        end
      end

      // Break or stuck-low line: hold off until the line is released.
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= bus.iRx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign bus.oParity_err = perr_q;
`else
  assign bus.oParity_err = 1'b0;
`endif

  assign bus.oData      = data_q;
  assign bus.oValid     = valid_q;
  assign bus.oFrame_err = ferr_q;
  assign bus.oBusy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses, a monitor pops them.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 160;
  localparam int K_VALID  = 0;
  localparam int K_FRAME  = 1;
  localparam int K_PARITY = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       busy_after;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  logic busy_pending;
  logic busy_exp;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16)
  ) dut (
    .iClk (clk),
    .iRst (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic mon_step();
    int   kind;
    int   npulse;
    exp_t e;
    if (busy_pending) begin
      check("busy_after_pulse", 32'(bus.oBusy), 32'(busy_exp));
      busy_pending = 1'b0;
    end
    npulse = int'(bus.oValid) + int'(bus.oFrame_err) + int'(bus.oParity_err);
    if (rst_n && npulse != 0) begin
      check("pulse_exclusive", 32'(npulse), 32'd1);
      kind = bus.oValid ? K_VALID : (bus.oFrame_err ? K_FRAME : K_PARITY);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(kind), 32'(e.kind));
        check("pulse_data", 32'(bus.oData), 32'(e.data));
        check("busy_at_pulse", 32'(bus.oBusy), 32'd1);
        busy_pending = 1'b1;
        busy_exp     = e.busy_after;
      end
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input logic busy_after);
    exp_t e;
    e.kind       = kind;
    e.data       = data;
    e.busy_after = busy_after;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    bus.iRx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    bus.iRx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(bus.oData),       32'h00);
    check({tag, "_valid"}, 32'(bus.oValid),      32'd0);
    check({tag, "_ferr"},  32'(bus.oFrame_err),  32'd0);
    check({tag, "_perr"},  32'(bus.oParity_err), 32'd0);
    check({tag, "_busy"},  32'(bus.oBusy),       32'd0);
  endtask

  initial begin
    int         busy_cnt;
    logic [7:0] c3;
    checks       = 0;
    failures     = 0;
    busy_pending = 1'b0;
    busy_exp     = 1'b0;
    rst_n        = 1'b0;
    bus.iRx      = 1'b1;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single good frame.
    push(K_VALID, 8'h55, 1'b0);
    send_frame(8'h55, 1'b1);
    repeat (50) @(negedge clk);

    // Back-to-back frames with no idle gap.
    push(K_VALID, 8'hA3, 1'b0);
    push(K_VALID, 8'h0F, 1'b0);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (100) @(negedge clk);

    // 40-clock glitch: false start, no pulses.
    busy_cnt = 0;
    bus.iRx  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.oBusy) busy_cnt++;
    end
    bus.iRx = 1'b1;
    repeat (160) begin
      @(negedge clk);
      if (bus.oBusy) busy_cnt++;
    end
    check("glitch_busy_seen", 32'(busy_cnt > 0), 32'd1);
    check("glitch_busy_short", 32'(busy_cnt < 90), 32'd1);
    check("glitch_idle_busy", 32'(bus.oBusy), 32'd0);

    // Framing error with the line held low for three bit times.
    push(K_FRAME, 8'h0F, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h81 >> i);
    bus.iRx = 1'b0;
    repeat (3 * BIT_CLKS - 1) @(negedge clk);
    check("ferr_busy_hold", 32'(bus.oBusy), 32'd1);
    check("ferr_data_hold", 32'(bus.oData), 32'h0F);
    bus.iRx = 1'b1;
    repeat (10) @(negedge clk);
    check("ferr_busy_release", 32'(bus.oBusy), 32'd0);
    repeat (20) @(negedge clk);

    // Reset in the middle of bit 4 of 0xC3, then a clean frame.
    c3 = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    bus.iRx = c3[4];
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    bus.iRx = 1'b1;
    repeat (10) @(negedge clk);
    check_all_zero("midreset_hold");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push(K_VALID, 8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (50) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Bad then good even parity on 0x07 (expected parity bit 1).
    push(K_PARITY, 8'h3C, 1'b0);
    send_frame_par(8'h07, 1'b0);
    push(K_VALID, 8'h07, 1'b0);
    send_frame_par(8'h07, 1'b1);
    bus.iRx = 1'b1;
    repeat (50) @(negedge clk);
`endif

    repeat (200) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
